// File: rtl/td4_decode_stage.sv
// TD4 decode stage: opcode -> src/dst/jnc controls + raw immediate, two-entry skid buffer.
// Latency 1 cycle; full throughput; in_ready registered (= skid empty), no comb path from out_ready/flush.
// Backpressure: first stalled cycle lands one word in skid, in_ready drops next edge. Optional trap FSM: DECODE_ILLEGAL_TRAP_EN.
module td4_decode_stage #(
    parameter int IM_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IM_W+3:0]   in_inst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_src,
    output logic [1:0]        out_dst,
    output logic [IM_W-1:0]   out_im,
    output logic              out_jnc,
    output logic              out_illegal,
    input  logic              trap_clr,
    output logic              halted
);

    typedef struct packed {
        logic [1:0]      src;
        logic [1:0]      dst;
        logic [IM_W-1:0] im;
        logic            jnc;
        logic            illegal;
    } entry_t;

    function automatic entry_t decode(input logic [IM_W+3:0] inst);
        entry_t     e;
        logic [3:0] op;
        op        = inst[IM_W+3:IM_W];
        e.src     = 2'd3;
        e.dst     = 2'd0;
        e.im      = inst[IM_W-1:0];
        e.jnc     = 1'b0;
        e.illegal = 1'b0;
        if (!op[3]) begin
            // Register-move group: low bits pick the source, bit 2 picks A/B.
            e.src = op[1:0];
            e.dst = {1'b0, op[2]};
        end else begin
            case (op)
                4'b1001: begin e.src = 2'd1; e.dst = 2'd2; end
                4'b1011: begin e.src = 2'd3; e.dst = 2'd2; end
                4'b1110: begin e.src = 2'd3; e.dst = 2'd3; e.jnc = 1'b1; end
                4'b1111: begin e.src = 2'd3; e.dst = 2'd3; end
                default: begin
                    // Illegal opcodes become a clear of A.
                    e.src     = 2'd3;
                    e.dst     = 2'd0;
                    e.im      = '0;
                    e.illegal = 1'b1;
                end
            endcase
        end
        return e;
    endfunction

    logic   main_vld, skid_vld;
    entry_t main_q, skid_q;
    logic   main_vld_n, skid_vld_n;
    entry_t main_n, skid_n;
    entry_t dec;
    logic   accept, consume;

    assign dec     = decode(in_inst);
    assign accept  = in_valid && in_ready;
    assign consume = main_vld && out_ready;

    always_comb begin
        main_vld_n = main_vld;
        main_n     = main_q;
        skid_vld_n = skid_vld;
        skid_n     = skid_q;
        if (flush) begin
            main_vld_n = 1'b0;
            skid_vld_n = 1'b0;
        end else if (!main_vld || consume) begin
            if (skid_vld) begin
                main_n     = skid_q;
                main_vld_n = 1'b1;
                skid_vld_n = accept;
                if (accept) skid_n = dec;
            end else begin
                main_vld_n = accept;
                if (accept) main_n = dec;
            end
        end else if (accept) begin
            skid_vld_n = 1'b1;
            skid_n     = dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_vld <= main_vld_n;
            skid_vld <= skid_vld_n;
            main_q   <= main_n;
            skid_q   <= skid_n;
        end
    end

    assign out_valid   = main_vld;
    assign out_src     = main_q.src;
    assign out_dst     = main_q.dst;
    assign out_im      = main_q.im;
    assign out_jnc     = main_q.jnc;
    assign out_illegal = main_q.illegal;

`ifdef DECODE_ILLEGAL_TRAP_EN
    typedef enum logic {RUN, HALT} state_t;
    state_t state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            halted   <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    // A dropped (flushed) illegal word must not trap.
                    if (accept && !flush && dec.illegal) begin
                        state    <= HALT;
                        halted   <= 1'b1;
                        in_ready <= 1'b0;
                    end else begin
                        in_ready <= !skid_vld_n;
                    end
                end
                HALT: begin
                    if (trap_clr) begin
                        state    <= RUN;
                        halted   <= 1'b0;
                        in_ready <= !skid_vld_n;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    halted   <= 1'b0;
                    in_ready <= !skid_vld_n;
                end
            endcase
        end
    end
`else
    logic unused_trap_clr;
    assign unused_trap_clr = trap_clr;
    assign halted          = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) in_ready <= 1'b1;
        else     in_ready <= !skid_vld_n;
    end
`endif

endmodule

// File: tb/tb_td4_decode_stage.sv
// Directed bench for td4_decode_stage (IM_W=4 and IM_W=8 instances); trap checks follow DECODE_ILLEGAL_TRAP_EN.
module tb_td4_decode_stage;
    logic clk, rst;

    logic       in_valid, in_ready, flush, out_valid, out_ready;
    logic [7:0] in_inst;
    logic [1:0] out_src, out_dst;
    logic [3:0] out_im;
    logic       out_jnc, out_illegal, trap_clr, halted;

    logic        v8, r8, f8, ov8, or8, j8, il8, tc8, h8;
    logic [11:0] inst8;
    logic [1:0]  s8, d8;
    logic [7:0]  im8;

    int n_cmp = 0;
    int n_fail = 0;

    logic [12:0] obs, exp13;
    logic [2:0]  ctl, exp3;
    logic [16:0] obs8, exp17;
    assign obs  = {in_ready, halted, out_valid, out_src, out_dst, out_im, out_jnc, out_illegal};
    assign ctl  = {in_ready, halted, out_valid};
    assign obs8 = {r8, h8, ov8, s8, d8, im8, j8, il8};

    logic [3:0] ops   [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'hE, 4'hF};
    logic [1:0] e_src [12] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd3, 2'd3};
    logic [1:0] e_dst [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

    td4_decode_stage #(.IM_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
        .out_dst(out_dst), .out_im(out_im), .out_jnc(out_jnc), .out_illegal(out_illegal),
        .trap_clr(trap_clr), .halted(halted));

    td4_decode_stage #(.IM_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_inst(inst8),
        .flush(f8), .out_valid(ov8), .out_ready(or8), .out_src(s8),
        .out_dst(d8), .out_im(im8), .out_jnc(j8), .out_illegal(il8),
        .trap_clr(tc8), .halted(h8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        exp13 = {1'b1, 1'b0, 1'b1 ^ 1'b1, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp13) begin n_fail++; $display("FAIL reset: got %h want %h", obs, exp13); end
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_stream();
        out_ready = 1'b1; in_valid = 1'b1;
        in_inst = 8'h35; step();
        exp13 = {1'b1, 1'b0, 1'b1, 2'd3, 2'd0, 4'h5, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp13) begin n_fail++; $display("FAIL stream_35: got %h want %h", obs, exp13); end
        in_inst = 8'h5A; step();
        exp13 = {1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 4'hA, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp13) begin n_fail++; $display("FAIL stream_5A: got %h want %h", obs, exp13); end
        in_inst = 8'hE3; step();
        exp13 = {1'b1, 1'b0, 1'b1, 2'd3, 2'd3, 4'h3, 1'b1, 1'b0};
        n_cmp++;
        if (obs !== exp13) begin n_fail++; $display("FAIL stream_E3: got %h want %h", obs, exp13); end
        in_valid = 1'b0; step();
        exp3 = 3'b100;
        n_cmp++;
        if (ctl !== exp3) begin n_fail++; $display("FAIL stream_drain: got %b want %b", ctl, exp3); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 8'h11; step();
        exp13 = {1'b1, 1'b0, 1'b1, 2'd1, 2'd0, 4'h1, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp13) begin n_fail++; $display("FAIL bp_first: got %h want %h", obs, exp13); end
        in_inst = 8'h22; step();
        exp13 = {1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 4'h1, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp13) begin n_fail++; $display("FAIL bp_skid: got %h want %h", obs, exp13); end
        in_inst = 8'h33; step();
        n_cmp++;
        if (obs !== exp13) begin n_fail++; $display("FAIL bp_hold: got %h want %h", obs, exp13); end
        in_valid = 1'b0; out_ready = 1'b1; step();
        exp13 = {1'b1, 1'b0, 1'b1, 2'd2, 2'd0, 4'h2, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp13) begin n_fail++; $display("FAIL bp_release: got %h want %h", obs, exp13); end
        step();
        exp3 = 3'b100;
        n_cmp++;
        if (ctl !== exp3) begin n_fail++; $display("FAIL bp_no_33: got %b want %b", ctl, exp3); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 8'h44; step();
        in_inst = 8'h55; step();
        exp3 = 3'b001;
        n_cmp++;
        if (ctl !== exp3) begin n_fail++; $display("FAIL flush_full: got %b want %b", ctl, exp3); end
        in_inst = 8'hF7; flush = 1'b1; step();
        exp3 = 3'b100;
        n_cmp++;
        if (ctl !== exp3) begin n_fail++; $display("FAIL flush_clear: got %b want %b", ctl, exp3); end
        flush = 1'b0; in_valid = 1'b0; step();
        n_cmp++;
        if (ctl !== exp3) begin n_fail++; $display("FAIL flush_no_F7: got %b want %b", ctl, exp3); end
        in_valid = 1'b1; in_inst = 8'h66; step();
        in_inst = 8'h77; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
        n_cmp++;
        if (ctl !== exp3) begin n_fail++; $display("FAIL flush_drop_hs: got %b want %b", ctl, exp3); end
    endtask

    task automatic test_opcodes();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_inst = {ops[i], 4'(i)};
            step();
            exp13 = {1'b1, 1'b0, 1'b1, e_src[i], e_dst[i], 4'(i), (ops[i] == 4'hE), 1'b0};
            n_cmp++;
            if (obs !== exp13) begin n_fail++; $display("FAIL opcode_%h: got %h want %h", ops[i], obs, exp13); end
        end
        in_valid = 1'b0; step();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1; in_valid = 1'b1;
        in_inst = 8'h8C; step();
`ifdef DECODE_ILLEGAL_TRAP_EN
        exp13 = {1'b0, 1'b1, 1'b1, 2'd3, 2'd0, 4'h0, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp13) begin n_fail++; $display("FAIL illegal_8C: got %h want %h", obs, exp13); end
        in_inst = 8'h6D; step();
        exp3 = 3'b010;
        n_cmp++;
        if (ctl !== exp3) begin n_fail++; $display("FAIL halt_hold: got %b want %b", ctl, exp3); end
        trap_clr = 1'b1; step();
        exp3 = 3'b100;
        n_cmp++;
        if (ctl !== exp3) begin n_fail++; $display("FAIL trap_clr: got %b want %b", ctl, exp3); end
        trap_clr = 1'b0; step();
`else
        exp13 = {1'b1, 1'b0, 1'b1, 2'd3, 2'd0, 4'h0, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp13) begin n_fail++; $display("FAIL illegal_8C: got %h want %h", obs, exp13); end
        in_inst = 8'hA5; step();
        n_cmp++;
        if (obs !== exp13) begin n_fail++; $display("FAIL illegal_A5: got %h want %h", obs, exp13); end
        in_inst = 8'hC3; step();
        n_cmp++;
        if (obs !== exp13) begin n_fail++; $display("FAIL illegal_C3: got %h want %h", obs, exp13); end
        in_inst = 8'hD1; step();
        n_cmp++;
        if (obs !== exp13) begin n_fail++; $display("FAIL illegal_D1: got %h want %h", obs, exp13); end
        in_inst = 8'h6D; step();
`endif
        exp13 = {1'b1, 1'b0, 1'b1, 2'd2, 2'd1, 4'hD, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp13) begin n_fail++; $display("FAIL after_illegal: got %h want %h", obs, exp13); end
        in_valid = 1'b0; step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 8'h11; step();
        in_inst = 8'h22; step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        exp13 = {1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp13) begin n_fail++; $display("FAIL reset_mid: got %h want %h", obs, exp13); end
        step();
        rst = 1'b0; out_ready = 1'b1;
        step();
    endtask

    task automatic test_im8();
        or8 = 1'b1; v8 = 1'b1;
        inst8 = 12'h7AB; step();
        exp17 = {1'b1, 1'b0, 1'b1, 2'd3, 2'd1, 8'hAB, 1'b0, 1'b0};
        n_cmp++;
        if (obs8 !== exp17) begin n_fail++; $display("FAIL im8_7AB: got %h want %h", obs8, exp17); end
        inst8 = 12'hB5F; step();
        exp17 = {1'b1, 1'b0, 1'b1, 2'd3, 2'd2, 8'h5F, 1'b0, 1'b0};
        n_cmp++;
        if (obs8 !== exp17) begin n_fail++; $display("FAIL im8_B5F: got %h want %h", obs8, exp17); end
        inst8 = 12'hE80; step();
        exp17 = {1'b1, 1'b0, 1'b1, 2'd3, 2'd3, 8'h80, 1'b1, 1'b0};
        n_cmp++;
        if (obs8 !== exp17) begin n_fail++; $display("FAIL im8_E80: got %h want %h", obs8, exp17); end
        v8 = 1'b0; step();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_inst = 8'h00; flush = 1'b0; out_ready = 1'b0; trap_clr = 1'b0;
        v8 = 1'b0; inst8 = 12'h000; f8 = 1'b0; or8 = 1'b0; tc8 = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_opcodes();
        test_illegal();
        test_reset_mid();
        test_im8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
